// File: rtl/xseq_pkg.sv
// ============================================================================
// Module  : xseq_pkg
// Brief   : State encodings and transition/output helpers for the X1/X2
//           sequence machine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package xseq_pkg;

    localparam logic [1:0] ST_A = 2'b00;
    localparam logic [1:0] ST_B = 2'b10;
    localparam logic [1:0] ST_C = 2'b11;
    localparam logic [1:0] ST_D = 2'b01;

    // x is {x1, x2}
    function automatic logic [1:0] xseq_next(input logic [1:0] state, input logic [1:0] x);
        logic [1:0] ns;
        ns = ST_A;
        case (state)
            ST_A: ns = (x == 2'b11) ? ST_B : ST_A;
            ST_B: begin
                case (x)
                    2'b01:   ns = ST_C;
                    2'b11:   ns = ST_B;
                    default: ns = ST_A;
                endcase
            end
            ST_C: begin
                case (x)
                    2'b10:   ns = ST_D;
                    2'b11:   ns = ST_B;
                    default: ns = ST_C;
                endcase
            end
            ST_D: ns = x[1] ? ST_D : ST_A;
            default: ns = ST_A;
        endcase
        return ns;
    endfunction

    // Returns {z1, z2}
    function automatic logic [1:0] xseq_z(input logic [1:0] ns, input logic [1:0] x);
        return {ns[1], (ns == ST_B) | ((ns == ST_D) & ~x[0])};
    endfunction

endpackage

`default_nettype wire

// File: rtl/xseq_ch_fsm.sv
// ============================================================================
// Module  : xseq_ch_fsm
// Brief   : One X1/X2 channel: input synchroniser, state and Z registers,
//           C->D event pulse and saturating event counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module xseq_ch_fsm
    import xseq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             x1,
    input  logic             x2,
    input  logic             cnt_clr,
    output logic             z1,
    output logic             z2,
    output logic             evt,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [1:0]       w_x;
    logic [1:0]       w_ns;
    logic             w_enter_d;
    logic [1:0]       r_state;
    logic             r_z1;
    logic             r_z2;
    logic             r_evt;
    logic [CNT_W-1:0] r_cnt;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [1:0] r_sync [SYNC_STAGES];

            // Synchroniser ignores en so a re-enabled channel sees current inputs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= 2'b00;
                    end
                end else begin
                    r_sync[0] <= {x1, x2};
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_x = r_sync[SYNC_STAGES-1];
        end else begin : g_bypass
            assign w_x = {x1, x2};
        end
    endgenerate

    assign w_ns      = xseq_next(r_state, w_x);
    assign w_enter_d = (r_state == ST_C) && (w_ns == ST_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_A;
            r_z1    <= 1'b0;
            r_z2    <= 1'b0;
            r_evt   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (en) begin
                r_state      <= w_ns;
                {r_z1, r_z2} <= xseq_z(w_ns, w_x);
                r_evt        <= w_enter_d;
            end else begin
                r_evt        <= 1'b0;
            end

            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (en && w_enter_d && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign z1  = r_z1;
    assign z2  = r_z2;
    assign evt = r_evt;
    assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/xseq_fsm_multi.sv
// ============================================================================
// Module  : xseq_fsm_multi
// Brief   : NUM_CH independent X1/X2 sequence machines with packed counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module xseq_fsm_multi
    import xseq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       x1,
    input  logic [NUM_CH-1:0]       x2,
    output logic [NUM_CH-1:0]       z1,
    output logic [NUM_CH-1:0]       z2,
    output logic [NUM_CH-1:0]       evt,
    input  logic                    cnt_clr,
    output logic [NUM_CH*CNT_W-1:0] cnt
);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            xseq_ch_fsm #(
                .SYNC_STAGES (SYNC_STAGES),
                .CNT_W       (CNT_W)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en[i]),
                .x1      (x1[i]),
                .x2      (x2[i]),
                .cnt_clr (cnt_clr),
                .z1      (z1[i]),
                .z2      (z2[i]),
                .evt     (evt[i]),
                .cnt     (cnt[i*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_xseq_fsm_multi.sv
// ============================================================================
// Module  : tb_xseq_fsm_multi
// Brief   : Directed and random checks of xseq_fsm_multi against a
//           table-driven behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_xseq_fsm_multi;

    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    localparam int A = 0, B = 1, C = 2, D = 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    cnt_clr = 1'b0;
    logic [NUM_CH-1:0]       en = '1;
    logic [NUM_CH-1:0]       x1 = '0;
    logic [NUM_CH-1:0]       x2 = '0;
    logic [NUM_CH-1:0]       z1, z2, evt;
    logic [NUM_CH*CNT_W-1:0] cnt;

    xseq_fsm_multi #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .x1      (x1),
        .x2      (x2),
        .z1      (z1),
        .z2      (z2),
        .evt     (evt),
        .cnt_clr (cnt_clr),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: next-state table indexed [state][x1*2+x2]
    int nxt [4][4] = '{'{A, A, A, B}, '{A, C, A, B}, '{C, C, D, B}, '{A, A, D, D}};
    int m_st  [NUM_CH];
    int m_z1  [NUM_CH];
    int m_z2  [NUM_CH];
    int m_evt [NUM_CH];
    int m_cnt [NUM_CH];
    int m_dl  [NUM_CH][SYNC_STAGES+1];

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = A; m_z1[c] = 0; m_z2[c] = 0; m_evt[c] = 0; m_cnt[c] = 0;
            for (int j = 0; j <= SYNC_STAGES; j++) m_dl[c][j] = 0;
        end
    endtask

    task automatic model_step();
        int raw, xs, ns, idx;
        bit enter;
        idx = (SYNC_STAGES == 0) ? 0 : SYNC_STAGES - 1;
        for (int c = 0; c < NUM_CH; c++) begin
            raw = int'(x1[c]) * 2 + int'(x2[c]);
            xs  = (SYNC_STAGES == 0) ? raw : m_dl[c][idx];
            for (int j = SYNC_STAGES - 1; j >= 1; j--) m_dl[c][j] = m_dl[c][j-1];
            m_dl[c][0] = raw;
            ns    = nxt[m_st[c]][xs];
            enter = (m_st[c] == C) && (ns == D);
            if (cnt_clr) m_cnt[c] = 0;
            else if (en[c] && enter && m_cnt[c] < CNT_MAX) m_cnt[c]++;
            if (en[c]) begin
                m_z1[c]  = (ns == B || ns == C) ? 1 : 0;
                m_z2[c]  = (ns == B || (ns == D && (xs % 2) == 0)) ? 1 : 0;
                m_evt[c] = enter ? 1 : 0;
                m_st[c]  = ns;
            end else begin
                m_evt[c] = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0]       ez1, ez2, eevt;
        logic [NUM_CH*CNT_W-1:0] ecnt;
        for (int c = 0; c < NUM_CH; c++) begin
            ez1[c]  = m_z1[c][0];
            ez2[c]  = m_z2[c][0];
            eevt[c] = m_evt[c][0];
            ecnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        end
        chk("z1", 32'(z1), 32'(ez1));
        chk("z2", 32'(z2), 32'(ez2));
        chk("evt", 32'(evt), 32'(eevt));
        chk("cnt", 32'(cnt), 32'(ecnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq  [8] = '{0, 1, 3, 1, 0, 2, 3, 1};
        int expz [8] = '{0, 0, 3, 2, 2, 1, 0, 0};
        int pat  [4] = '{3, 1, 2, 0};
        int s, n;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_z1", 32'(z1), 0);
        chk("rst_z2", 32'(z2), 0);
        chk("rst_evt", 32'(evt), 0);
        chk("rst_cnt", 32'(cnt), 0);
        rst_n = 1'b1;

        // 1: legacy sequence on ch0
        n = 0;
        for (int i = 0; i < 8; i++) begin
            s = seq[i];
            x1[0] = s[1];
            x2[0] = s[0];
            repeat (5) begin
                tick();
                if (evt[0]) n++;
            end
            chk("t1_z", 32'({z1[0], z2[0]}), 32'(expz[i]));
        end
        chk("t1_evt_count", 32'(n), 1);
        chk("t1_cnt0", 32'(cnt[0 +: CNT_W]), 1);
        x1[0] = 1'b0; x2[0] = 1'b0;
        repeat (SYNC_STAGES + 2) tick();

        // 2: latency on ch1
        x1[1] = 1'b1; x2[1] = 1'b1;
        for (int i = 1; i <= SYNC_STAGES + 1; i++) begin
            tick();
            chk("t2_latency", 32'({z1[1], z2[1]}), (i == SYNC_STAGES + 1) ? 3 : 0);
        end
        x1[1] = 1'b0; x2[1] = 1'b0;
        repeat (SYNC_STAGES + 2) tick();

        // 3: saturation, then clear coinciding with an event on ch2
        for (int r = 0; r < 17; r++) begin
            for (int p = 0; p < 4; p++) begin
                s = pat[p];
                x1[2] = s[1]; x2[2] = s[0];
                tick();
            end
        end
        repeat (SYNC_STAGES + 1) tick();
        chk("t3_sat", 32'(cnt[2*CNT_W +: CNT_W]), CNT_MAX);
        x1[2] = 1'b1; x2[2] = 1'b1; tick();
        x1[2] = 1'b0; x2[2] = 1'b1; tick();
        x1[2] = 1'b1; x2[2] = 1'b0;
        for (int i = 0; i <= SYNC_STAGES; i++) begin
            if (i == SYNC_STAGES) cnt_clr = 1'b1;
            tick();
            if (i == 0) begin x1[2] = 1'b0; x2[2] = 1'b0; end
        end
        cnt_clr = 1'b0;
        chk("t3_clr_evt", 32'(evt[2]), 1);
        chk("t3_clr_cnt", 32'(cnt[2*CNT_W +: CNT_W]), 0);
        repeat (SYNC_STAGES + 2) tick();

        // 4: enable freeze on ch3
        x1[3] = 1'b1; x2[3] = 1'b1; tick();
        x1[3] = 1'b0; x2[3] = 1'b1;
        repeat (SYNC_STAGES + 1) tick();
        chk("t4_inC", 32'({z1[3], z2[3]}), 2);
        en[3] = 1'b0;
        x1[3] = 1'b1; x2[3] = 1'b0;
        n = 0;
        repeat (10) begin
            tick();
            if (evt[3]) n++;
        end
        chk("t4_frozen_z", 32'({z1[3], z2[3]}), 2);
        chk("t4_frozen_evt", 32'(n), 0);
        en[3] = 1'b1;
        tick();
        chk("t4_reen_z", 32'({z1[3], z2[3]}), 1);
        chk("t4_reen_evt", 32'(evt[3]), 1);
        tick();
        chk("t4_evt_once", 32'(evt[3]), 0);

        // 5: async reset with channels in B, C, D, D
        x1[2:0] = 3'b111; x2[2:0] = 3'b111; tick();
        x1[2:1] = 2'b00;  x2[2:1] = 2'b11;  tick();
        x1[2]   = 1'b1;   x2[2]   = 1'b0;
        repeat (SYNC_STAGES + 2) tick();
        chk("t5_pre_z1", 32'(z1), 32'h3);
        chk("t5_pre_z2", 32'(z2), 32'hD);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_z1", 32'(z1), 0);
        chk("t5_rst_z2", 32'(z2), 0);
        chk("t5_rst_evt", 32'(evt), 0);
        chk("t5_rst_cnt", 32'(cnt), 0);
        model_reset();
        #2;
        rst_n = 1'b1;
        x1 = '1; x2 = '1;
        repeat (SYNC_STAGES + 1) tick();
        chk("t5_recover_z1", 32'(z1), 32'hF);
        chk("t5_recover_z2", 32'(z2), 32'hF);

        // 6: random traffic on all channels
        repeat (10000) begin
            x1      = NUM_CH'($urandom);
            x2      = NUM_CH'($urandom);
            en      = NUM_CH'($urandom | $urandom);
            cnt_clr = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
